// File: rtl/enduro_fifo_wr_arb.sv
// Round-robin, burst-based arbiter sharing the enduro FIFO write port among NUM_CH AXI-Stream sources.
// Define ENDURO_FIFO_ARB_PKT_LOCK_EN to hold each grant until tlast (no MAX_BURST limit).
module enduro_fifo_wr_arb #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                         s_axis_clk,
    input  logic                         s_axis_aresetn,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_tdata,
    input  logic [NUM_CH-1:0]            ch_tvalid,
    input  logic [NUM_CH-1:0]            ch_tlast,
    output logic [NUM_CH-1:0]            ch_tready,
    output logic [DATA_WIDTH-1:0]        fifo_wr_data,
    output logic                         fifo_inc_wr_pointer,
    input  logic                         fifo_full_ff,
    input  logic                         fifo_almost_full_ff,
    output logic [CH_W-1:0]              grant_ch,
    output logic                         busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CH_W-1:0]     r_grant_ch;
    logic [CH_W-1:0]     r_last_grant;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [CH_W-1:0]     w_sel_ch;
    logic                w_sel_valid;
    logic [CH_W:0]       w_rr_sum;
    logic                w_grant_load;
    logic                w_ready_grant;
    logic                w_beat;
    logic                w_last_beat;
    logic                w_exit;
    logic [DATA_WIDTH-1:0] w_ch_data [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign w_ch_data[gi] = ch_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search last_grant+1 .. last_grant+NUM_CH; the conditional subtract keeps non-power-of-two NUM_CH correct.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_sel_valid = 1'b0;
        w_sel_ch    = '0;
        w_rr_sum    = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            w_rr_sum = {1'b0, r_last_grant} + (CH_W+1)'(off);
            if (w_rr_sum >= (CH_W+1)'(NUM_CH))
                w_rr_sum = w_rr_sum - (CH_W+1)'(NUM_CH);
            if (!w_sel_valid && ch_tvalid[w_rr_sum[CH_W-1:0]]) begin
                w_sel_valid = 1'b1;
                w_sel_ch    = w_rr_sum[CH_W-1:0];
            end
        end
    end

    assign w_ready_grant = (r_state == ST_XFER) && !fifo_full_ff;
    assign w_beat        = w_ready_grant && ch_tvalid[r_grant_ch];
    assign w_last_beat   = w_beat && ch_tlast[r_grant_ch];
    assign w_grant_load  = (r_state == ST_IDLE) && w_sel_valid && !fifo_almost_full_ff;

`ifdef ENDURO_FIFO_ARB_PKT_LOCK_EN
    assign w_exit     = w_last_beat;
    assign w_cnt_next = (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + CNT_W'(1);
`else
    logic [CNT_W:0] w_cnt_inc;
    assign w_cnt_inc  = {1'b0, r_beat_cnt} + (CNT_W+1)'(1);
    assign w_exit     = w_last_beat || (w_beat && (w_cnt_inc == (CNT_W+1)'(MAX_BURST)));
    assign w_cnt_next = w_cnt_inc[CNT_W-1:0];
`endif

    always_comb begin
        ch_tready = '0;
        if (w_ready_grant)
            ch_tready[r_grant_ch] = 1'b1;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_load) w_next_state = ST_XFER;
            ST_XFER: if (w_exit)       w_next_state = ST_IDLE;
            default:                   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_axis_clk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            r_state      <= ST_IDLE;
            r_grant_ch   <= '0;
            r_last_grant <= CH_W'(NUM_CH - 1);
            r_beat_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_load) begin
                r_grant_ch   <= w_sel_ch;
                r_last_grant <= w_sel_ch;
                r_beat_cnt   <= '0;
            end else if (w_beat) begin
                r_beat_cnt   <= w_cnt_next;
            end
        end
    end

    assign fifo_inc_wr_pointer = w_beat;
    assign fifo_wr_data        = w_ch_data[r_grant_ch];
    assign grant_ch            = r_grant_ch;
    assign busy                = (r_state == ST_XFER);

endmodule

// File: tb/tb_enduro_fifo_wr_arb.sv
// Self-checking bench for enduro_fifo_wr_arb: directed scenarios plus randomized traffic
// scored against a transaction-level round-robin model.
module tb_enduro_fifo_wr_arb;

    localparam int NUM_CH    = 4;
    localparam int DW        = 32;
    localparam int MAX_BURST = 16;
    localparam int CH_W      = $clog2(NUM_CH);
`ifdef ENDURO_FIFO_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_CH*DW-1:0] ch_tdata = '0;
    logic [NUM_CH-1:0]    ch_tvalid = '0;
    logic [NUM_CH-1:0]    ch_tlast = '0;
    logic [NUM_CH-1:0]    ch_tready;
    logic [DW-1:0]        fifo_wr_data;
    logic                 fifo_inc_wr_pointer;
    logic                 fifo_full_ff = 1'b0;
    logic                 fifo_almost_full_ff = 1'b0;
    logic [CH_W-1:0]      grant_ch;
    logic                 busy;

    enduro_fifo_wr_arb #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)) dut (
        .s_axis_clk          (clk),
        .s_axis_aresetn      (rst_n),
        .ch_tdata            (ch_tdata),
        .ch_tvalid           (ch_tvalid),
        .ch_tlast            (ch_tlast),
        .ch_tready           (ch_tready),
        .fifo_wr_data        (fifo_wr_data),
        .fifo_inc_wr_pointer (fifo_inc_wr_pointer),
        .fifo_full_ff        (fifo_full_ff),
        .fifo_almost_full_ff (fifo_almost_full_ff),
        .grant_ch            (grant_ch),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0] q_data [NUM_CH][$];
    bit            q_last [NUM_CH][$];
    exp_t          exp_q[$];
    int            wr_log[$];
    int            wr_cyc[$];
    int            m_last;
    int            n_pass = 0;
    int            n_total = 0;
    int            cyc = 0;
    bit            rnd_full = 0, rnd_af = 0, drv_full = 0, drv_af = 0;
    logic          s_inc, s_busy;
    logic [DW-1:0] s_data;
    logic [CH_W-1:0] s_grant;
    logic [NUM_CH-1:0] s_ready;

    task automatic push_pkt(input int ch, input int len, input logic [DW-1:0] base, input bit rnd);
        for (int k = 0; k < len; k++) begin
            q_data[ch].push_back(rnd ? DW'($urandom) : base + DW'(k));
            q_last[ch].push_back(k == len - 1);
        end
    endtask

    // Expected write order: pick next non-empty channel after the last grant, take beats until tlast or burst limit.
    task automatic model_schedule();
        int  idx [NUM_CH];
        int  ch, n, c;
        bit  found, last, done;
        exp_t e;
        for (int i = 0; i < NUM_CH; i++) idx[i] = 0;
        done = 0;
        while (!done) begin
            found = 0;
            ch = 0;
            for (int off = 1; off <= NUM_CH; off++) begin
                c = (m_last + off) % NUM_CH;
                if (!found && idx[c] < q_data[c].size()) begin
                    found = 1;
                    ch = c;
                end
            end
            if (!found) begin
                done = 1;
            end else begin
                m_last = ch;
                n = 0;
                do begin
                    e.ch = ch;
                    e.data = q_data[ch][idx[ch]];
                    exp_q.push_back(e);
                    last = q_last[ch][idx[ch]];
                    idx[ch]++;
                    n++;
                end while (!last && (LOCK || n < MAX_BURST) && idx[ch] < q_data[ch].size());
            end
        end
    endtask

    task automatic tick();
        logic [NUM_CH-1:0] hs, exp_rdy;
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) begin
            if (q_data[i].size() > 0) begin
                ch_tvalid[i] = 1'b1;
                ch_tdata[i*DW +: DW] = q_data[i][0];
                ch_tlast[i] = q_last[i][0];
            end else begin
                ch_tvalid[i] = 1'b0;
                ch_tdata[i*DW +: DW] = '0;
                ch_tlast[i] = 1'b0;
            end
        end
        fifo_full_ff        = rnd_full ? ($urandom_range(0, 3) == 0) : drv_full;
        fifo_almost_full_ff = rnd_af   ? ($urandom_range(0, 2) == 0) : drv_af;
        #1;
        s_inc = fifo_inc_wr_pointer; s_data = fifo_wr_data; s_grant = grant_ch;
        s_busy = busy; s_ready = ch_tready;
        cyc++;
        hs = s_ready & ch_tvalid;
        exp_rdy = '0;
        if (s_busy === 1'b1 && !fifo_full_ff) exp_rdy[s_grant] = 1'b1;
        n_total++;
        if (s_ready !== exp_rdy) $display("FAIL ready cyc=%0d got=%b want=%b", cyc, s_ready, exp_rdy);
        else n_pass++;
        n_total++;
        if (s_inc !== (|hs)) $display("FAIL inc_strobe cyc=%0d got=%b want=%b", cyc, s_inc, |hs);
        else n_pass++;
        if (s_inc === 1'b1) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write cyc=%0d got ch%0d data=%h want no write", cyc, s_grant, s_data);
            end else begin
                e = exp_q.pop_front();
                if (s_grant !== CH_W'(e.ch) || s_data !== e.data)
                    $display("FAIL write cyc=%0d got ch%0d %h want ch%0d %h", cyc, s_grant, s_data, e.ch, e.data);
                else n_pass++;
            end
            wr_log.push_back(int'(s_grant));
            wr_cyc.push_back(cyc);
        end
        for (int i = 0; i < NUM_CH; i++)
            if (hs[i]) begin
                void'(q_data[i].pop_front());
                void'(q_last[i].pop_front());
            end
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((exp_q.size() > 0 || s_busy === 1'b1) && n < budget);
        n_total++;
        if (exp_q.size() != 0 || s_busy !== 1'b0)
            $display("FAIL %s_drain got %0d beats pending busy=%b want 0 pending busy=0", name, exp_q.size(), s_busy);
        else n_pass++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_CH; i++) begin
            q_data[i].delete();
            q_last[i].delete();
        end
        exp_q.delete();
        rnd_full = 0; rnd_af = 0; drv_full = 0; drv_af = 0;
        ch_tvalid = '0; ch_tlast = '0; ch_tdata = '0;
        fifo_full_ff = 1'b0; fifo_almost_full_ff = 1'b0;
        m_last = NUM_CH - 1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ch_tvalid = '1; ch_tlast = '1;
        repeat (2) begin
            @(negedge clk); #1;
            n_total++;
            if (busy !== 1'b0 || ch_tready !== '0 || fifo_inc_wr_pointer !== 1'b0 || grant_ch !== '0)
                $display("FAIL reset_state got busy=%b rdy=%b inc=%b grant=%0d want 0,0,0,0",
                         busy, ch_tready, fifo_inc_wr_pointer, grant_ch);
            else n_pass++;
        end
        apply_reset();
    endtask

    task automatic test_single_packet();
        apply_reset();
        push_pkt(1, 3, 32'hA0, 0);
        model_schedule();
        tick();
        n_total++;
        if (s_busy !== 1'b0 || s_inc !== 1'b0) $display("FAIL single_idle got busy=%b inc=%b want 0,0", s_busy, s_inc);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if (s_inc !== 1'b1 || s_grant !== CH_W'(1) || s_data !== 32'hA0 + DW'(k))
                $display("FAIL single_beat%0d got inc=%b ch%0d %h want 1 ch1 %h", k, s_inc, s_grant, s_data, 32'hA0 + k);
            else n_pass++;
        end
        tick();
        n_total++;
        if (s_busy !== 1'b0 || s_inc !== 1'b0) $display("FAIL single_done got busy=%b inc=%b want 0,0", s_busy, s_inc);
        else n_pass++;
    endtask

    task automatic test_rotation();
        int start, n;
        apply_reset();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < NUM_CH; c++) push_pkt(c, 1, DW'(c * 256 + r), 0);
        model_schedule();
        start = wr_log.size();
        n = 0;
        while (wr_log.size() - start < 3 * NUM_CH && n < 60) begin
            tick();
            n++;
        end
        n_total++;
        if (wr_log.size() - start != 3 * NUM_CH)
            $display("FAIL rotation_count got %0d want %0d", wr_log.size() - start, 3 * NUM_CH);
        else begin
            n_pass++;
            for (int k = 0; k < 3 * NUM_CH; k++) begin
                n_total++;
                if (wr_log[start+k] != k % NUM_CH || (k > 0 && wr_cyc[start+k] - wr_cyc[start+k-1] != 2))
                    $display("FAIL rotation%0d got ch%0d gap=%0d want ch%0d gap=2", k, wr_log[start+k],
                             k > 0 ? wr_cyc[start+k] - wr_cyc[start+k-1] : 2, k % NUM_CH);
                else n_pass++;
            end
        end
        drain(10, "rotation");
    endtask

    task automatic test_max_burst();
        int start;
        int run_ch[$], run_len[$], exp_ch[$], exp_len[$];
        apply_reset();
        push_pkt(0, 40, 32'h1000, 0);
        push_pkt(2, 2, 32'h2000, 0);
        model_schedule();
        start = wr_log.size();
        drain(200, "burst");
        for (int k = start; k < wr_log.size(); k++) begin
            if (run_ch.size() > 0 && run_ch[$] == wr_log[k]) run_len[$] = run_len[$] + 1;
            else begin
                run_ch.push_back(wr_log[k]);
                run_len.push_back(1);
            end
        end
        if (LOCK) begin
            exp_ch = '{0, 2};     exp_len = '{40, 2};
        end else begin
            exp_ch = '{0, 2, 0};  exp_len = '{16, 2, 24};
        end
        n_total++;
        if (run_ch.size() != exp_ch.size()) $display("FAIL burst_runs got %0d want %0d", run_ch.size(), exp_ch.size());
        else begin
            n_pass++;
            for (int k = 0; k < exp_ch.size(); k++) begin
                n_total++;
                if (run_ch[k] != exp_ch[k] || run_len[k] != exp_len[k])
                    $display("FAIL burst_run%0d got ch%0d x%0d want ch%0d x%0d", k, run_ch[k], run_len[k], exp_ch[k], exp_len[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_full_stall();
        int start, n;
        apply_reset();
        push_pkt(3, 6, 32'h300, 0);
        model_schedule();
        start = wr_log.size();
        n = 0;
        do begin
            tick();
            n++;
        end while (s_inc !== 1'b1 && n < 10);
        drv_full = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_total++;
            if (s_ready !== '0 || s_inc !== 1'b0 || s_busy !== 1'b1)
                $display("FAIL stall%0d got rdy=%b inc=%b busy=%b want 0,0,1", k, s_ready, s_inc, s_busy);
            else n_pass++;
        end
        drv_full = 0;
        tick();
        n_total++;
        if (s_inc !== 1'b1 || s_data !== 32'h301) $display("FAIL stall_resume got inc=%b %h want 1 301", s_inc, s_data);
        else n_pass++;
        drain(20, "stall");
        n_total++;
        if (wr_log.size() - start != 6) $display("FAIL stall_beats got %0d want 6", wr_log.size() - start);
        else n_pass++;
    endtask

    task automatic test_almost_full();
        apply_reset();
        drv_af = 1;
        push_pkt(3, 1, 32'h3A, 0);
        model_schedule();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if (s_busy !== 1'b0 || s_inc !== 1'b0) $display("FAIL af_hold%0d got busy=%b inc=%b want 0,0", k, s_busy, s_inc);
            else n_pass++;
        end
        drv_af = 0;
        tick();
        tick();
        n_total++;
        if (s_grant !== CH_W'(3) || s_busy !== 1'b1 || s_inc !== 1'b1)
            $display("FAIL af_release got ch%0d busy=%b inc=%b want ch3 1 1", s_grant, s_busy, s_inc);
        else n_pass++;
        drain(10, "af");
    endtask

    task automatic test_async_reset();
        int start, n;
        apply_reset();
        push_pkt(1, 4, 32'hB0, 0);
        model_schedule();
        n = 0;
        do begin
            tick();
            n++;
        end while (s_inc !== 1'b1 && n < 10);
        tick();
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if (ch_tready !== '0 || busy !== 1'b0 || fifo_inc_wr_pointer !== 1'b0)
            $display("FAIL async_reset got rdy=%b busy=%b inc=%b want 0,0,0", ch_tready, busy, fifo_inc_wr_pointer);
        else n_pass++;
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_pkt(0, 1, 32'hC0, 0);
        push_pkt(2, 1, 32'hC2, 0);
        model_schedule();
        start = wr_log.size();
        drain(20, "post_reset");
        n_total++;
        if (wr_log.size() - start != 2 || wr_log[start] != 0 || wr_log[start+1] != 2)
            $display("FAIL post_reset_order got %0d writes first ch%0d want ch0 then ch2", wr_log.size() - start,
                     wr_log.size() > start ? wr_log[start] : -1);
        else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) push_pkt(c, $urandom_range(1, 24), '0, 1);
            end
            model_schedule();
            rnd_full = 1; rnd_af = 1;
            drain(3000, "random");
            rnd_full = 0; rnd_af = 0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        m_last = NUM_CH - 1;
        test_reset();
        test_single_packet();
        test_rotation();
        test_max_burst();
        test_full_stall();
        test_almost_full();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
